// File: rtl/flick_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM, press pulse/counter,
// and a step_tick pacing generator realigned on every accepted press.
module flick_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flick_raw,
    input  logic       tick_en,
    output logic       flick_pulse,
    output logic       flick_level,
    output logic       step_tick,
    output logic [7:0] press_count
);

    localparam logic [1:0] RELEASED     = 2'b00;
    localparam logic [1:0] PRESS_WAIT   = 2'b01;
    localparam logic [1:0] PRESSED      = 2'b11;
    localparam logic [1:0] RELEASE_WAIT = 2'b10;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    logic             s1;
    logic             s2;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             accept;

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        accept    = 1'b0;
        case (state)
            RELEASED: begin
                if (s2) begin
                    state_nxt = PRESS_WAIT;
                    deb_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_nxt = RELEASED;
                end else if (deb_cnt == DEB_MAX) begin
                    state_nxt = PRESSED;
                    accept    = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_nxt = RELEASE_WAIT;
                    deb_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_nxt = PRESSED;
                end else if (deb_cnt == DEB_MAX) begin
                    state_nxt = RELEASED;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= RELEASED;
            deb_cnt     <= '0;
            flick_level <= 1'b0;
            flick_pulse <= 1'b0;
            press_count <= 8'd0;
        end else begin
            s1          <= flick_raw;
            s2          <= s1;
            state       <= state_nxt;
            deb_cnt     <= deb_nxt;
            flick_level <= state_nxt[1];
            flick_pulse <= accept;
            if (accept && press_count != 8'hFF) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    // A press realigns the step phase and suppresses any coincident tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (accept) begin
            tick_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (tick_en) begin
            if (tick_cnt == TICK_MAX) begin
                tick_cnt  <= '0;
                step_tick <= 1'b1;
            end else begin
                tick_cnt  <= tick_cnt + 1'b1;
                step_tick <= 1'b0;
            end
        end else begin
            step_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flick_conditioner.sv
// Directed self-checking bench for flick_conditioner at default parameters.
module tb_flick_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       flick_raw;
    logic       tick_en;
    logic       flick_pulse;
    logic       flick_level;
    logic       step_tick;
    logic [7:0] press_count;

    int n_cmp = 0;
    int n_err = 0;

    flick_conditioner dut (
        .clk(clk),
        .reset(reset),
        .flick_raw(flick_raw),
        .tick_en(tick_en),
        .flick_pulse(flick_pulse),
        .flick_level(flick_level),
        .step_tick(step_tick),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int pulses, pulse_edge, level_edge, min_level, max_level;
    int nt, t1, t2, tick_at_pulse;

    initial begin
        reset     = 1'b1;
        flick_raw = 1'b0;
        tick_en   = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_pulse", int'(flick_pulse), 0);
        check("rst_level", int'(flick_level), 0);
        check("rst_tick", int'(step_tick), 0);
        check("rst_count", int'(press_count), 0);
        cyc(2);
        reset = 1'b1;
        cyc(3);

        // T2 bounce
        pulses = 0; max_level = 0;
        flick_raw = 1'b1; cyc(1);
        flick_raw = 1'b0; cyc(1);
        flick_raw = 1'b1; cyc(1);
        flick_raw = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cyc(1);
            if (flick_pulse) pulses++;
            if (flick_level) max_level = 1;
        end
        check("t2_pulses", pulses, 0);
        check("t2_level", max_level, 0);
        check("t2_count", int'(press_count), 0);

        // T1 clean press
        pulses = 0; pulse_edge = 0; level_edge = 0;
        flick_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (flick_pulse) begin
                pulses++;
                pulse_edge = i;
            end
            if (flick_level && level_edge == 0) level_edge = i;
        end
        check("t1_pulses", pulses, 1);
        check("t1_pulse_edge", pulse_edge, 7);
        check("t1_level_edge", level_edge, 7);
        check("t1_level", int'(flick_level), 1);
        check("t1_count", int'(press_count), 1);
        check("t1_tick_off", int'(step_tick), 0);

        // T3 release glitch
        pulses = 0; min_level = 1;
        flick_raw = 1'b0;
        cyc(1);
        if (!flick_level) min_level = 0;
        flick_raw = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (flick_pulse) pulses++;
            if (!flick_level) min_level = 0;
        end
        check("t3_pulses", pulses, 0);
        check("t3_level", min_level, 1);
        check("t3_count", int'(press_count), 1);
        flick_raw = 1'b0;
        cyc(15);
        check("t3_released", int'(flick_level), 0);

        // T4 tick generator, phase starts at 0 after the T1 press
        nt = 0; t1 = 0; t2 = 0;
        tick_en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (step_tick) begin
                nt++;
                if (nt == 1) t1 = i;
                if (nt == 2) t2 = i;
            end
        end
        check("t4_ticks", nt, 2);
        check("t4_first", t1, 8);
        check("t4_second", t2, 16);
        nt = 0;
        tick_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (step_tick) nt++;
        end
        check("t4_pause", nt, 0);
        nt = 0; t1 = 0;
        tick_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            if (step_tick) begin
                nt++;
                if (nt == 1) t1 = i;
            end
        end
        check("t4_resume_ticks", nt, 1);
        check("t4_resume_edge", t1, 4);

        // T5 press accepted on the same edge as a tick wrap
        pulse_edge = 0; t1 = 0; tick_at_pulse = -1;
        flick_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (flick_pulse) begin
                pulse_edge = i;
                tick_at_pulse = int'(step_tick);
            end
            if (step_tick && t1 == 0) t1 = i;
        end
        check("t5_pulse_edge", pulse_edge, 7);
        check("t5_tick_dropped", tick_at_pulse, 0);
        check("t5_next_tick", t1, 15);
        check("t5_count", int'(press_count), 2);
        flick_raw = 1'b0;
        cyc(15);

        // T6 reset mid PRESS_WAIT with button held
        tick_en = 1'b0;
        flick_raw = 1'b1;
        cyc(4);
        reset = 1'b0;
        #1;
        check("t6_rst_pulse", int'(flick_pulse), 0);
        check("t6_rst_level", int'(flick_level), 0);
        check("t6_rst_tick", int'(step_tick), 0);
        check("t6_rst_count", int'(press_count), 0);
        cyc(2);
        reset = 1'b1;
        pulses = 0; pulse_edge = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (flick_pulse) begin
                pulses++;
                pulse_edge = i;
            end
        end
        check("t6_pulses", pulses, 1);
        check("t6_pulse_edge", pulse_edge, 7);
        check("t6_count", int'(press_count), 1);
        flick_raw = 1'b0;
        cyc(12);

        for (int p = 0; p < 256; p++) begin
            flick_raw = 1'b1;
            cyc(10);
            flick_raw = 1'b0;
            cyc(10);
            if (p == 253) check("t6_count_255", int'(press_count), 255);
        end
        check("t6_count_sat", int'(press_count), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
